if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- IF stage of the MIPS pipelined CPU: PC register, instruction-memory request/acknowledge handshake, and the IF/ID pipeline register.
- Its output word is the `instruction` consumed by the ID-stage controller.
- Takes the stall (`hazard_detected`, as freeze) and resolved branch/jump redirects from ID.
- Tolerates variable instruction-memory latency without losing or duplicating words.

Parameters:
WORD_LEN, 32, data/address width (matches `WORD_LEN in defines.v)
RESET_PC, 32'h0000_0000, PC value after reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
freeze  input  1  ID stall (hazard_detected); IF/ID must hold
branch_taken  input  1  ID resolved taken branch/jump this cycle
branch_target  input  WORD_LEN  redirect PC, valid with branch_taken
imem_req  output  1  fetch request
imem_addr  output  WORD_LEN  fetch address, word aligned
imem_rdata  input  WORD_LEN  fetched word, valid with imem_ack
imem_ack  input  1  transfer completes on a clock edge where imem_req && imem_ack
if_instruction  output  WORD_LEN  IF/ID instruction to controller
if_pc_plus4  output  WORD_LEN  IF/ID PC+4 for branch target calculation
if_valid  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC; state=FETCH; imem_req=0; imem_addr=RESET_PC.
  - if_instruction=0 (nop); if_pc_plus4=0; if_valid=0; hold buffer empty.
  - First request is issued in the first cycle after reset release.
- Handshake:
  - Once imem_req=1, imem_addr is stable and req stays high until ack. No abandonment; redirects are handled by draining.
  - Zero-wait memory is legal: ack in the same cycle as req.
  - Back-to-back requests are allowed with req held high.
- FSM states:
  - FETCH: req=1, addr=pc.
    - ack && !freeze: IF/ID <= {imem_rdata, pc+4}, valid=1; pc <= pc+4; stay in FETCH.
    - ack && freeze: buffer <= {imem_rdata, pc+4}; pc <= pc+4; go to HOLD.
    - No ack: stay in FETCH.
  - HOLD: req=0.
    - When freeze=0: IF/ID <= buffer, valid=1; go to FETCH.
  - DRAIN: req=1 with the old address held.
    - On ack, the returned word is discarded; go to FETCH with addr=pc (the redirect target).
- branch_taken has the highest priority over freeze and ack:
  - IF/ID <= {0, 0}, valid=0 (flush to nop).
  - pc <= branch_target; the HOLD buffer is discarded.
  - From FETCH without ack: go to DRAIN. From FETCH with ack: drop the word, go to FETCH. From HOLD: go to FETCH.
  - branch_taken in DRAIN: update pc only, stay in DRAIN.
- freeze without branch_taken: IF/ID outputs hold their values bit-for-bit.
- PC arithmetic: +4 modulo 2^WORD_LEN, so 32'hFFFF_FFFC wraps to 0. branch_target[1:0] is ignored and forced to 00.
- Every fetched word reaches IF/ID exactly once unless flushed. No word reaches IF/ID twice.
- Reset mid-transfer: the outstanding transfer is abandoned and the memory sees req drop.

Optional Feature:
- Macro: `IF_BRANCH_DELAY_SLOT_EN`.
- Defined: MIPS delay slot. The word at the PC following the branch is not flushed:
  - If it completes in the branch cycle, it loads into IF/ID normally.
  - If it is outstanding, it is kept (no DRAIN); it loads on ack, then fetch proceeds from branch_target.
  - If it is in the HOLD buffer, it is forwarded.
  - pc is still redirected to branch_target.
- Undefined: flush/drain behaviour as above; the delay-slot word is discarded.

Test Plan:
1. Zero-wait memory (ack=1 always), no stalls, imem returns addr as data -> if_instruction sequence 0,4,8,... one per cycle; if_pc_plus4 = instruction+4; first valid 2 cycles after reset release.
2. ack with 3-cycle latency -> imem_addr stable through each wait; IF/ID updates every 4th cycle; no duplicate or missing words.
3. freeze=1 for 5 cycles while a word at 0x10 completes -> IF/ID holds the prior word (0x0C); req=0 in HOLD; on freeze drop, 0x10 enters IF/ID, then fetch resumes at 0x14.
4. branch_taken with target 0x100 while req at 0x20 is outstanding (ack 2 cycles later) -> IF/ID flushed to 0 with valid=0; the 0x20 word is discarded; next imem_addr=0x100. With `IF_BRANCH_DELAY_SLOT_EN`, the 0x20 word enters IF/ID, then 0x100.
5. branch_taken and freeze asserted together with target 0x40 -> branch wins: flush, then fetch at 0x40.
6. pc=0xFFFF_FFFC fetch completes -> pc wraps to 0; rst pulsed low mid-wait -> all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the IF stage (master) and
// the instruction memory (slave).
interface if_fetch_stage_if #(
  parameter int unsigned WORD_LEN = 32
);
  logic                imem_req;
  logic [WORD_LEN-1:0] imem_addr;
  logic [WORD_LEN-1:0] imem_rdata;
  logic                imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: PC, imem req/ack fetch FSM and IF/ID register.
// Define IF_BRANCH_DELAY_SLOT_EN to keep the delay-slot word instead of flushing it.
module if_fetch_stage #(
  parameter int unsigned         WORD_LEN = 32,
  parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                branch_taken,
  input  logic [WORD_LEN-1:0] branch_target,
  if_fetch_stage_if.master    imem,
  output logic [WORD_LEN-1:0] if_instruction,
  output logic [WORD_LEN-1:0] if_pc_plus4,
  output logic                if_valid
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_DRAIN
  } state_t;

  localparam logic [WORD_LEN-1:0] C_FOUR   = WORD_LEN'(4);
  localparam logic [WORD_LEN-1:0] C_ALIGNM = ~WORD_LEN'(3);

  state_t              r_state;
  logic                r_req;
  logic [WORD_LEN-1:0] r_addr;
  logic [WORD_LEN-1:0] r_pc;
  logic [WORD_LEN-1:0] r_instr;
  logic [WORD_LEN-1:0] r_pc4;
  logic                r_valid;
  logic [WORD_LEN-1:0] r_buf_instr;
  logic [WORD_LEN-1:0] r_buf_pc4;
`ifdef IF_BRANCH_DELAY_SLOT_EN
  logic                r_dslot;
`endif

  logic                w_xfer;
  logic [WORD_LEN-1:0] w_tgt;
  logic [WORD_LEN-1:0] w_addr_p4;
  logic [WORD_LEN-1:0] w_pc_seq;

  assign w_xfer    = r_req & imem.imem_ack;
  assign w_tgt     = branch_target & C_ALIGNM;
  // PC+4 is taken from the address actually fetched, so it stays right for a
  // delay-slot word that completes after pc was already redirected.
  assign w_addr_p4 = r_addr + C_FOUR;
`ifdef IF_BRANCH_DELAY_SLOT_EN
  assign w_pc_seq  = r_dslot ? r_pc : r_pc + C_FOUR;
`else
  assign w_pc_seq  = r_pc + C_FOUR;
`endif

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_addr;
  assign if_instruction = r_instr;
  assign if_pc_plus4    = r_pc4;
  assign if_valid       = r_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_FETCH;
      r_req       <= 1'b0;
      r_addr      <= RESET_PC;
      r_pc        <= RESET_PC;
      r_instr     <= '0;
      r_pc4       <= '0;
      r_valid     <= 1'b0;
      r_buf_instr <= '0;
      r_buf_pc4   <= '0;
`ifdef IF_BRANCH_DELAY_SLOT_EN
      r_dslot     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH: begin
          if (branch_taken) begin
            r_pc    <= w_tgt;
            r_instr <= '0;
            r_pc4   <= '0;
            r_valid <= 1'b0;
`ifdef IF_BRANCH_DELAY_SLOT_EN
            if (w_xfer) begin
              r_dslot <= 1'b0;
              if (freeze) begin
                r_buf_instr <= imem.imem_rdata;
                r_buf_pc4   <= w_addr_p4;
                r_req       <= 1'b0;
                r_state     <= S_HOLD;
              end else begin
                r_instr <= imem.imem_rdata;
                r_pc4   <= w_addr_p4;
                r_valid <= 1'b1;
                r_addr  <= w_tgt;
              end
            end else if (r_req) begin
              r_dslot <= 1'b1;
            end else begin
              r_req  <= 1'b1;
              r_addr <= w_tgt;
            end
`else
            // An outstanding request cannot be withdrawn; drain it first.
            if (r_req && !imem.imem_ack) begin
              r_state <= S_DRAIN;
            end else begin
              r_req  <= 1'b1;
              r_addr <= w_tgt;
            end
`endif
          end else if (w_xfer) begin
            r_pc <= w_pc_seq;
`ifdef IF_BRANCH_DELAY_SLOT_EN
            r_dslot <= 1'b0;
`endif
            if (freeze) begin
              r_buf_instr <= imem.imem_rdata;
              r_buf_pc4   <= w_addr_p4;
              r_req       <= 1'b0;
              r_state     <= S_HOLD;
            end else begin
              r_instr <= imem.imem_rdata;
              r_pc4   <= w_addr_p4;
              r_valid <= 1'b1;
              r_addr  <= w_pc_seq;
            end
          end else begin
            r_req <= 1'b1;
          end
        end

        S_HOLD: begin
          if (branch_taken) begin
            r_pc    <= w_tgt;
            r_addr  <= w_tgt;
            r_req   <= 1'b1;
            r_state <= S_FETCH;
`ifdef IF_BRANCH_DELAY_SLOT_EN
            r_instr <= r_buf_instr;
            r_pc4   <= r_buf_pc4;
            r_valid <= 1'b1;
`else
            r_instr <= '0;
            r_pc4   <= '0;
            r_valid <= 1'b0;
`endif
          end else if (!freeze) begin
            r_instr <= r_buf_instr;
            r_pc4   <= r_buf_pc4;
            r_valid <= 1'b1;
            r_addr  <= r_pc;
            r_req   <= 1'b1;
            r_state <= S_FETCH;
          end
        end

        S_DRAIN: begin
          if (branch_taken) begin
            r_pc <= w_tgt;
          end
          if (imem.imem_ack) begin
            r_addr  <= branch_taken ? w_tgt : r_pc;
            r_state <= S_FETCH;
          end
        end

        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: memory model with settable latency, IF/ID
// scoreboard queue, handshake stability checks. Honours IF_BRANCH_DELAY_SLOT_EN.
module tb_if_fetch_stage;

  typedef struct packed {
    logic        v;
    logic [31:0] i;
    logic [31:0] p;
  } ifid_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        bt;
  logic [31:0] tgt;
  logic [31:0] if_instruction;
  logic [31:0] if_pc_plus4;
  logic        if_valid;

  int          total = 0;
  int          bad   = 0;
  int unsigned lat   = 0;
  int unsigned wcnt;
  logic        pend;
  logic [31:0] held_addr;
  ifid_t       q[$];

  if_fetch_stage_if #(.WORD_LEN(32)) bus ();

  if_fetch_stage #(
    .WORD_LEN(32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (bt),
    .branch_target  (tgt),
    .imem           (bus.master),
    .if_instruction (if_instruction),
    .if_pc_plus4    (if_pc_plus4),
    .if_valid       (if_valid)
  );

  always #5 clk = ~clk;

  // Memory: returns the address as data, acks after lat waiting cycles.
  always_comb begin
    bus.imem_ack   = bus.imem_req && (wcnt >= lat);
    bus.imem_rdata = bus.imem_addr;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt <= 0;
      pend <= 1'b0;
    end else if (bus.imem_req && bus.imem_ack) begin
      wcnt <= 0;
      pend <= 1'b0;
    end else if (bus.imem_req) begin
      wcnt      <= wcnt + 1;
      pend      <= 1'b1;
      held_addr <= bus.imem_addr;
    end
  end

  // IF/ID monitor: every change of the IF/ID outputs is one produced entry.
  initial begin
    ifid_t prev;
    ifid_t cur;
    ifid_t exp;
    prev = '0;
    forever begin
      @(posedge clk);
      #1;
      cur = {if_valid, if_instruction, if_pc_plus4};
      if (rst !== 1'b1) begin
        prev = '0;
      end else begin
        if (pend) begin
          total++;
          assert ({bus.imem_req, bus.imem_addr} === {1'b1, held_addr}) else begin
            bad++;
            $error("FAIL hs_stable: got req=%0b addr=%h want req=1 addr=%h",
                   bus.imem_req, bus.imem_addr, held_addr);
          end
        end
        if (cur !== prev) begin
          total++;
          assert (q.size() != 0) else begin
            bad++;
            $error("FAIL ifid_extra: got v=%0b i=%h p=%h want no output (queue empty)",
                   cur.v, cur.i, cur.p);
          end
          if (q.size() != 0) begin
            exp = q.pop_front();
            total++;
            assert (cur === exp) else begin
              bad++;
              $error("FAIL ifid: got v=%0b i=%h p=%h want v=%0b i=%h p=%h",
                     cur.v, cur.i, cur.p, exp.v, exp.i, exp.p);
            end
          end
          prev = cur;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic v, input logic [31:0] i, input logic [31:0] p);
    q.push_back({v, i, p});
  endtask

  task automatic pw(input logic [31:0] a);
    push(1'b1, a, a + 32'd4);
  endtask

  task automatic start_phase(input int unsigned l);
    rst    = 1'b0;
    freeze = 1'b0;
    bt     = 1'b0;
    tgt    = '0;
    lat    = l;
    cyc(2);
    rst    = 1'b1;
  endtask

  task automatic end_phase(input string tag);
    chk(tag, 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst    = 1'b0;
    freeze = 1'b0;
    bt     = 1'b0;
    tgt    = '0;
    cyc(3);
    chk("rst_req",   {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr",  bus.imem_addr, 32'h0);
    chk("rst_instr", if_instruction, 32'h0);
    chk("rst_pc4",   if_pc_plus4, 32'h0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);

    // 1: zero-wait stream, one word per cycle
    start_phase(0);
    for (int a = 0; a < 32; a += 4) pw(32'(a));
    cyc(1);
    chk("p1_first_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("p1_first_addr", bus.imem_addr, 32'h0);
    chk("p1_e1_valid",   {31'd0, if_valid}, 32'd0);
    cyc(1);
    chk("p1_e2_valid",   {31'd0, if_valid}, 32'd1);
    cyc(7);
    end_phase("p1_drained");

    // 2: 3-cycle latency, a word every 4th cycle
    start_phase(3);
    for (int a = 0; a < 16; a += 4) pw(32'(a));
    cyc(4);
    chk("p2_e4_valid", {31'd0, if_valid}, 32'd0);
    cyc(12);
    chk("p2_e16_left", 32'(q.size()), 32'd1);
    cyc(1);
    end_phase("p2_drained");

    // 3: freeze while 0x10 completes
    start_phase(0);
    for (int a = 0; a < 24; a += 4) pw(32'(a));
    cyc(5);
    freeze = 1'b1;
    cyc(1);
    chk("p3_hold_req",   {31'd0, bus.imem_req}, 32'd0);
    chk("p3_hold_instr", if_instruction, 32'h0C);
    cyc(4);
    chk("p3_end_req",    {31'd0, bus.imem_req}, 32'd0);
    chk("p3_end_instr",  if_instruction, 32'h0C);
    freeze = 1'b0;
    cyc(1);
    chk("p3_rel_instr",  if_instruction, 32'h10);
    chk("p3_rel_addr",   bus.imem_addr, 32'h14);
    cyc(1);
    end_phase("p3_drained");

    // 4: branch to 0x100 with the 0x20 fetch outstanding
    start_phase(0);
    for (int a = 0; a < 32; a += 4) pw(32'(a));
    push(1'b0, 32'h0, 32'h0);
`ifdef IF_BRANCH_DELAY_SLOT_EN
    pw(32'h20);
`endif
    pw(32'h100);
    cyc(9);
    chk("p4_out_addr", bus.imem_addr, 32'h20);
    lat = 2;
    bt  = 1'b1;
    tgt = 32'h0000_0102;
    cyc(1);
    bt  = 1'b0;
    chk("p4_flush_valid", {31'd0, if_valid}, 32'd0);
    chk("p4_flush_instr", if_instruction, 32'h0);
    chk("p4_wait_addr",   bus.imem_addr, 32'h20);
    cyc(1);
    chk("p4_wait_req",    {31'd0, bus.imem_req}, 32'd1);
    cyc(1);
    chk("p4_tgt_addr",    bus.imem_addr, 32'h100);
    cyc(3);
    end_phase("p4_drained");

    // 5: branch and freeze together
    start_phase(0);
    for (int a = 0; a < 16; a += 4) pw(32'(a));
    push(1'b0, 32'h0, 32'h0);
`ifdef IF_BRANCH_DELAY_SLOT_EN
    pw(32'h10);
    pw(32'h40);
`else
    pw(32'h40);
    pw(32'h44);
`endif
    cyc(5);
    freeze = 1'b1;
    bt     = 1'b1;
    tgt    = 32'h40;
    cyc(1);
    freeze = 1'b0;
    bt     = 1'b0;
    chk("p5_flush_valid", {31'd0, if_valid}, 32'd0);
    chk("p5_flush_instr", if_instruction, 32'h0);
`ifdef IF_BRANCH_DELAY_SLOT_EN
    chk("p5_hold_req",    {31'd0, bus.imem_req}, 32'd0);
`else
    chk("p5_tgt_addr",    bus.imem_addr, 32'h40);
`endif
    cyc(2);
    end_phase("p5_drained");

    // 6: PC wrap at 0xFFFF_FFFC, then async reset mid-wait
    start_phase(0);
    pw(32'h0);
`ifdef IF_BRANCH_DELAY_SLOT_EN
    pw(32'h4);
`else
    push(1'b0, 32'h0, 32'h0);
`endif
    push(1'b1, 32'hFFFF_FFFC, 32'h0);
    pw(32'h0);
    cyc(2);
    bt  = 1'b1;
    tgt = 32'hFFFF_FFFC;
    cyc(1);
    bt  = 1'b0;
    chk("p6_top_addr",  bus.imem_addr, 32'hFFFF_FFFC);
    cyc(1);
    chk("p6_wrap_addr", bus.imem_addr, 32'h0);
    chk("p6_wrap_pc4",  if_pc_plus4, 32'h0);
    cyc(1);
    end_phase("p6_drained");
    lat = 3;
    cyc(2);
    chk("p6_wait_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("p6_wait_addr", bus.imem_addr, 32'h4);
    #2;
    rst = 1'b0;
    #1;
    chk("p6_arst_req",   {31'd0, bus.imem_req}, 32'd0);
    chk("p6_arst_addr",  bus.imem_addr, 32'h0);
    chk("p6_arst_instr", if_instruction, 32'h0);
    chk("p6_arst_pc4",   if_pc_plus4, 32'h0);
    chk("p6_arst_valid", {31'd0, if_valid}, 32'd0);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
